mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning address width in words.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 64, meaning max cycles in WAIT before abort (TIMEOUT ≥ 2).

Interface
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst in 1, async active-low reset.
REQ-005 The block SHALL have req0/req1 in 1, level request from requester 0/1, held until its done.
REQ-006 The block SHALL have we0/we1 in 1, write enable per requester.
REQ-007 The block SHALL have addr0/addr1 in ADDR_W, word address per requester.
REQ-008 The block SHALL have wdata0/wdata1 in DATA_W, write data per requester.
REQ-009 The block SHALL have done0/done1 out 1, one-cycle completion pulse per requester.
REQ-010 The block SHALL have err0/err1 out 1, valid with done, meaning the transaction timed out.
REQ-011 The block SHALL have rdata out DATA_W, read data, valid in the done cycle and shared by both requesters.
REQ-012 The block SHALL have busy out 1, high in any state other than IDLE.
REQ-013 The block SHALL have gnt_id out 1, the requester currently owned and valid while busy.
REQ-014 The block SHALL have mem_req out 1, mem_we out 1, mem_addr out ADDR_W and mem_wdata out DATA_W, the memory-side command.
REQ-015 The block SHALL have mem_ready in 1, mem_done in 1 (one-cycle pulse) and mem_rdata in DATA_W, the memory-side response.

Function
REQ-016 The block SHALL implement FSM states IDLE, ISSUE, WAIT and RESP, all registered.
REQ-017 In IDLE, if req0 or req1 is high, the block SHALL select a winner, latch its we/addr/wdata into the mem_* registers, set gnt_id, and go to ISSUE.
REQ-018 The block SHALL use round-robin arbitration: when both requests are high, the requester not granted last wins; a lone requester always wins.
REQ-019 The last-granted register SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 In ISSUE, mem_req SHALL be high; on an edge where mem_ready is high, the block SHALL go to WAIT and drop mem_req; otherwise it SHALL stay in ISSUE.
REQ-021 mem_we, mem_addr and mem_wdata SHALL be held constant from ISSUE entry until RESP exit; the memory samples the address at completion.
REQ-022 In WAIT, on mem_done high, the block SHALL register mem_rdata into rdata and go to RESP.
REQ-023 A WAIT cycle counter SHALL clear on WAIT entry; if it reaches TIMEOUT-1 without mem_done, the block SHALL go to RESP with the error flag set and rdata set to 0.
REQ-024 In RESP, the block SHALL pulse done[gnt_id] for exactly one cycle, drive err[gnt_id] with the error flag, update last-granted to gnt_id, and go to IDLE.
REQ-025 done_x SHALL occur exactly 1 cycle after mem_done, or TIMEOUT+1 cycles after WAIT entry on timeout.
REQ-026 A requester SHALL deassert req on the edge ending its done cycle; a req still high in the following IDLE cycle SHALL be treated as a new transaction.
REQ-027 Requests from the non-owner SHALL be ignored while busy and remain pending.
REQ-028 mem_req SHALL never be high outside ISSUE, and at most one memory transaction SHALL be outstanding at a time.
REQ-029 The block SHALL ignore a mem_done pulse arriving in IDLE, ISSUE or RESP.
REQ-030 done0, done1, err0 and err1 SHALL never be high in the same cycle as each other's counterpart.

Reset
REQ-031 When rst is low, asynchronously: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done0=done1=0, err0=err1=0, rdata=0, busy=0, gnt_id=0, last-granted=1, counter=0.
REQ-032 Reset asserted mid-transaction SHALL abort it with no done pulse; operation SHALL restart in IDLE after deassertion.

Verification
REQ-033 Single read: req0, addr0=0x0010, memory LATENCY=8 initialized mem[i]=i -> one mem_req accepted, done0 one cycle after mem_done, rdata=0x00000010, err0=0.
REQ-034 Write then read: req1, we1=1, addr1=0x0005, wdata1=0xDEADBEEF, then a read of 0x0005 -> second done1 with rdata=0xDEADBEEF.
REQ-035 Simultaneous: req0 and req1 raised in the same cycle after reset -> requester 0 served first, requester 1 second; repeat with both -> requester 1 first (alternation).
REQ-036 mem_ready low for 5 cycles during ISSUE -> mem_req stays high 6 cycles, address stable, exactly one transaction.
REQ-037 Timeout: TIMEOUT=16, memory never returns mem_done -> done0=1, err0=1, rdata=0 at 17 cycles after WAIT entry; busy falls the next cycle.
REQ-038 rst low 1 cycle during WAIT -> all outputs at reset values immediately, no done pulse; the next request completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-outstanding memory port.
// Each grant runs IDLE -> ISSUE -> WAIT -> RESP, with a WAIT-cycle timeout that completes the grant with an error.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              gnt_id,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        o_dbg_state
);

    localparam int               CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_load;
    logic               w_winner;
    logic               w_cap_done;
    logic               w_cap_to;
    logic               r_gnt;
    logic               r_last;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // On a tie the requester that was not served last wins; a lone requester always wins.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_winner   = 1'b0;
        w_cap_done = 1'b0;
        w_cap_to   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_load   = 1'b1;
                    w_winner = (req0 && req1) ? ~r_last : req1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_ready) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done) begin
                    w_cap_done = 1'b1;
                    w_next     = S_RESP;
                end else if (r_cnt == CNT_MAX) begin
                    w_cap_to = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // The command registers only change on a new grant, so they stay stable through RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_load) begin
                r_gnt   <= w_winner;
                r_we    <= w_winner ? we1 : we0;
                r_addr  <= w_winner ? addr1 : addr0;
                r_wdata <= w_winner ? wdata1 : wdata0;
                r_err   <= 1'b0;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_cap_done) begin
                r_rdata <= mem_rdata;
                r_err   <= 1'b0;
            end else if (w_cap_to) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
            if (r_state == S_RESP) begin
                r_last <= r_gnt;
            end
        end
    end

    assign done0       = (r_state == S_RESP) && !r_gnt;
    assign done1       = (r_state == S_RESP) &&  r_gnt;
    assign err0        = done0 && r_err;
    assign err1        = done1 && r_err;
    assign rdata       = r_rdata;
    assign busy        = (r_state != S_IDLE);
    assign gnt_id      = r_gnt;
    assign mem_req     = (r_state == S_ISSUE);
    assign mem_we      = r_we;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both requesters and an 8-cycle-latency memory.
// Inputs change and outputs are checked on the falling clock edge.
module tb_mem_arbiter;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int LAT     = 8;

  logic              clk;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              done0, done1, err0, err1;
  logic [DATA_W-1:0] rdata;
  logic              busy, gnt_id;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready, mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] mem [0:255];
  int n_checks;
  int n_fail;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata), .busy(busy), .gnt_id(gnt_id),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Serves one grant from the memory side. The caller has raised the request at a
  // falling edge while the arbiter is idle. done_cyc counts falling edges from the
  // first WAIT cycle (counted as 1) to the first one showing the done pulse.
  task automatic serve(input logic exp_id, input logic [ADDR_W-1:0] exp_addr,
                       input logic exp_we, input logic [DATA_W-1:0] exp_wdata,
                       input int ready_delay, input int exp_issue, input bit respond,
                       input logic [DATA_W-1:0] exp_rdata, input logic exp_err,
                       input int exp_cyc);
    int n;
    int issue_cnt;
    int cyc;
    n = 0;
    while (!mem_req && n < 10) begin
      tick();
      n++;
    end
    check("issue_seen", mem_req, 1'b1);
    check("gnt_id", gnt_id, exp_id);
    check("mem_addr", mem_addr, exp_addr);
    check("mem_we", mem_we, exp_we);
    check("mem_wdata", mem_wdata, exp_wdata);
    issue_cnt = 1;
    for (int i = 0; i < ready_delay; i++) begin
      mem_done = (i == 0);
      tick();
      if (mem_req) issue_cnt++;
      check("issue_addr_stable", mem_addr, exp_addr);
    end
    mem_done  = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("issue_cycles", issue_cnt, exp_issue);
    check("mem_req_dropped", mem_req, 1'b0);
    cyc = 1;
    while (!(done0 || done1) && cyc < 40) begin
      check("wait_gnt_hold", gnt_id, exp_id);
      check("wait_addr_stable", mem_addr, exp_addr);
      if (respond && cyc == LAT) begin
        if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
        mem_rdata = mem[mem_addr[7:0]];
        mem_done  = 1'b1;
      end else begin
        mem_done = 1'b0;
      end
      tick();
      cyc++;
    end
    mem_done = 1'b0;
    check("done_latency", cyc, exp_cyc);
    check("done0", done0, (exp_id == 1'b0));
    check("done1", done1, (exp_id == 1'b1));
    check("err0", err0, (exp_id == 1'b0) && exp_err);
    check("err1", err1, (exp_id == 1'b1) && exp_err);
    check("rdata", rdata, exp_rdata);
    check("resp_addr_stable", mem_addr, exp_addr);
    if (exp_id) req1 = 1'b0;
    else req0 = 1'b0;
    tick();
    check("idle_busy", busy, 1'b0);
    check("idle_done", {done1, done0}, 2'b00);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = i;

    // reset state
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_done_err", {done1, done0, err1, err0}, 4'b0000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_gnt_id", gnt_id, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    rst = 1'b1;
    tick();

    // stray mem_done while idle is ignored
    mem_done = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_done = 1'b0;
    check("stray_done_busy", busy, 1'b0);
    check("stray_done_rdata", rdata, 32'h0);
    check("stray_done_pulse", {done1, done0}, 2'b00);
    tick();

    // single read of 0x0010
    addr0 = 16'h0010; we0 = 1'b0; req0 = 1'b1;
    serve(1'b0, 16'h0010, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0010, 1'b0, 9);

    // write then read back by requester 1
    addr1 = 16'h0005; we1 = 1'b1; wdata1 = 32'hDEAD_BEEF; req1 = 1'b1;
    serve(1'b1, 16'h0005, 1'b1, 32'hDEAD_BEEF, 0, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 9);
    we1 = 1'b0; req1 = 1'b1;
    serve(1'b1, 16'h0005, 1'b0, 32'hDEAD_BEEF, 0, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 9);

    // simultaneous requests after reset: 0 first, then with 0 re-requesting, 1 wins the tie
    rst = 1'b0;
    tick();
    rst = 1'b1;
    addr0 = 16'h0030; addr1 = 16'h0031; req0 = 1'b1; req1 = 1'b1;
    serve(1'b0, 16'h0030, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0030, 1'b0, 9);
    addr0 = 16'h0032; req0 = 1'b1;
    serve(1'b1, 16'h0031, 1'b0, 32'hDEAD_BEEF, 0, 1, 1'b1, 32'h0000_0031, 1'b0, 9);
    serve(1'b0, 16'h0032, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0032, 1'b0, 9);

    // mem_ready held low for 5 ISSUE cycles
    addr1 = 16'h0007; req1 = 1'b1;
    serve(1'b1, 16'h0007, 1'b0, 32'hDEAD_BEEF, 5, 6, 1'b1, 32'h0000_0007, 1'b0, 9);

    // reset pulse during WAIT aborts with no done pulse
    addr0 = 16'h0020; req0 = 1'b1;
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check("abort_in_wait", dbg_state, 2'd2);
    tick();
    tick();
    rst = 1'b0; req0 = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_mem_addr", mem_addr, 16'h0000);
    check("abort_rdata", rdata, 32'h0);
    check("abort_done_err", {done1, done0, err1, err0}, 4'b0000);
    check("abort_state", dbg_state, 2'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post_abort_done", {done1, done0}, 2'b00);
    check("post_abort_busy", busy, 1'b0);
    req0 = 1'b1;
    serve(1'b0, 16'h0020, 1'b0, 32'h0, 0, 1, 1'b1, 32'h0000_0020, 1'b0, 9);

    // memory never answers: timeout with error and zero data
    addr0 = 16'h0012; req0 = 1'b1;
    serve(1'b0, 16'h0012, 1'b0, 32'h0, 0, 1, 1'b0, 32'h0, 1'b1, 17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
